// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: FSM state type,
// key index width helper and the 4x4 legend lookup.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_t;

    // Width of a key index for an n-key matrix (never less than 1 bit).
    function automatic int unsigned key_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Printed legend of the standard 4x4 keypad, indexed by row*4 + col.
    function automatic logic [3:0] key_legend(input logic [3:0] idx);
        logic [3:0] v;
        case (idx)
            4'd0:    v = 4'h1;
            4'd1:    v = 4'h2;
            4'd2:    v = 4'h3;
            4'd3:    v = 4'hA;
            4'd4:    v = 4'h4;
            4'd5:    v = 4'h5;
            4'd6:    v = 4'h6;
            4'd7:    v = 4'hB;
            4'd8:    v = 4'h7;
            4'd9:    v = 4'h8;
            4'd10:   v = 4'h9;
            4'd11:   v = 4'hC;
            4'd12:   v = 4'hE;
            4'd13:   v = 4'h0;
            4'd14:   v = 4'hF;
            default: v = 4'hD;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/keypad_frame_scan.sv
// Row driver, column synchroniser and per-frame key snapshot.
// Produces a frame_end pulse on the last dwell cycle of the last row, along
// with the full pressed-key bitmap summary for that frame.
module keypad_frame_scan
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned KW       = key_idx_w(ROWS * COLS)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [COLS-1:0] i_column,
    input  logic [KW-1:0]   i_cand,
    output logic [ROWS-1:0] o_row,
    output logic            o_frame_end,
    output logic            o_hit_valid,
    output logic [KW-1:0]   o_hit,
    output logic            o_multi,
    output logic            o_cand_seen
);

    localparam int unsigned NK = ROWS * COLS;
    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned RW = $clog2(ROWS);

    logic [DW-1:0]   r_dwell;
    logic [RW-1:0]   r_row_idx;
    logic [COLS-1:0] r_sync1;
    logic [COLS-1:0] r_sync2;
    logic [NK-1:0]   r_acc;

    logic            w_last_dwell;
    logic [NK-1:0]   w_frame_bits;
    logic [ROWS-1:0] w_row;
    logic            w_hit_valid;
    logic [KW-1:0]   w_hit;
    logic            w_multi;
    logic            w_cand_seen;

    assign w_last_dwell = (r_dwell == DW'(SCAN_DIV - 1));

    // Two-flop synchroniser for the pulled-up (idle-high) column pins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= i_column;
            r_sync2 <= r_sync1;
        end
    end

    // Bitmap as it will stand after this cycle's sample: stored rows plus the
    // live synchronised columns for the row currently driven.
    always_comb begin
        w_frame_bits = r_acc;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (RW'(r) == r_row_idx) begin
                w_frame_bits[r*COLS +: COLS] = ~r_sync2;
            end
        end
    end

    // Dwell counter, row rotation and per-row capture on the last dwell cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dwell   <= '0;
            r_row_idx <= '0;
            r_acc     <= '0;
        end else if (w_last_dwell) begin
            r_dwell   <= '0;
            r_row_idx <= (r_row_idx == RW'(ROWS - 1)) ? '0 : r_row_idx + RW'(1);
            r_acc     <= w_frame_bits;
        end else begin
            r_dwell <= r_dwell + DW'(1);
        end
    end

    // One-cold row drive decoded from the row index.
    always_comb begin
        w_row = '1;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (RW'(r) == r_row_idx) begin
                w_row[r] = 1'b0;
            end
        end
    end

    // Frame summary: lowest pressed index, more-than-one flag, candidate presence.
    always_comb begin
        w_hit_valid = 1'b0;
        w_hit       = '0;
        w_multi     = 1'b0;
        w_cand_seen = 1'b0;
        for (int unsigned i = 0; i < NK; i++) begin
            if (w_frame_bits[i]) begin
                if (w_hit_valid) begin
                    w_multi = 1'b1;
                end else begin
                    w_hit_valid = 1'b1;
                    w_hit       = KW'(i);
                end
                if (KW'(i) == i_cand) begin
                    w_cand_seen = 1'b1;
                end
            end
        end
    end

    assign o_row       = w_row;
    assign o_frame_end = w_last_dwell && (r_row_idx == RW'(ROWS - 1));
    assign o_hit_valid = w_hit_valid;
    assign o_hit       = w_hit;
    assign o_multi     = w_multi;
    assign o_cand_seen = w_cand_seen;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner/debouncer top level: press/release FSM, debounce
// counter and output strobes. Typematic auto-repeat is built only when the
// macro KEYPAD_REPEAT_EN is defined.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned REPEAT_DELAY    = 32,
    parameter int unsigned REPEAT_RATE     = 8,
    localparam int unsigned KW             = key_idx_w(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] column,
    output logic [ROWS-1:0] row,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held,
    output logic            key_release
);

    localparam int unsigned DBW = $clog2(DEBOUNCE_FRAMES + 1);

    kp_state_t      r_state;
    logic [DBW-1:0] r_cnt;
    logic [KW-1:0]  r_cand;
    logic [KW-1:0]  r_key_code;
    logic           r_key_valid;
    logic           r_key_held;
    logic           r_key_release;

    logic           w_frame_end;
    logic           w_hit_valid;
    logic [KW-1:0]  w_hit;
    logic           w_multi;
    logic           w_cand_seen;

    kp_state_t      w_state_nx;
    logic [DBW-1:0] w_cnt_nx;
    logic [KW-1:0]  w_cand_nx;
    logic           w_accept;
    logic           w_release;
    logic           w_single;
    logic           w_rep_fire;

    keypad_frame_scan #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .KW       (KW)
    ) u_frame_scan (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_column    (column),
        .i_cand      (r_cand),
        .o_row       (row),
        .o_frame_end (w_frame_end),
        .o_hit_valid (w_hit_valid),
        .o_hit       (w_hit),
        .o_multi     (w_multi),
        .o_cand_seen (w_cand_seen)
    );

    assign w_single = w_hit_valid && !w_multi;

    // Next-state logic, evaluated only on the frame_end cycle.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_accept   = 1'b0;
        w_release  = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_single) begin
                        w_cand_nx = w_hit;
                        if (DEBOUNCE_FRAMES == 1) begin
                            w_state_nx = ST_PRESSED;
                            w_accept   = 1'b1;
                        end else begin
                            w_state_nx = ST_DEBOUNCE;
                            w_cnt_nx   = DBW'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_single && (w_hit == r_cand)) begin
                        if (r_cnt + DBW'(1) == DBW'(DEBOUNCE_FRAMES)) begin
                            w_state_nx = ST_PRESSED;
                            w_accept   = 1'b1;
                        end else begin
                            w_cnt_nx = r_cnt + DBW'(1);
                        end
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (!w_cand_seen) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            w_state_nx = ST_IDLE;
                            w_release  = 1'b1;
                        end else begin
                            w_state_nx = ST_RELEASE;
                            w_cnt_nx   = DBW'(1);
                        end
                    end
                end
                default: begin
                    if (w_cand_seen) begin
                        w_state_nx = ST_PRESSED;
                    end else if (r_cnt + DBW'(1) == DBW'(DEBOUNCE_FRAMES)) begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = '0;
                        w_release  = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + DBW'(1);
                    end
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [15:0] r_rep_cnt;
    logic        r_rep_started;
    logic [15:0] w_rep_target;
    logic        w_rep_step;

    // First repeat waits REPEAT_DELAY frames, later ones REPEAT_RATE frames.
    always_comb begin
        w_rep_target = r_rep_started ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY);
        w_rep_step   = w_frame_end && (r_state == ST_PRESSED) && w_cand_seen;
        w_rep_fire   = w_rep_step && (r_rep_cnt + 16'd1 == w_rep_target);
    end

    // Repeat counter: cleared on a fresh accept, frozen outside PRESSED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt     <= '0;
            r_rep_started <= 1'b0;
        end else if (w_accept) begin
            r_rep_cnt     <= '0;
            r_rep_started <= 1'b0;
        end else if (w_rep_step) begin
            if (w_rep_fire) begin
                r_rep_cnt     <= '0;
                r_rep_started <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + 16'd1;
            end
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // FSM state and registered outputs; strobes appear the cycle after frame_end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_cand        <= '0;
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_held    <= 1'b0;
            r_key_release <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_cand        <= w_cand_nx;
            r_key_valid   <= w_accept || w_rep_fire;
            r_key_release <= w_release;
            if (w_accept) begin
                r_key_code <= w_cand_nx;
                r_key_held <= 1'b1;
            end else if (w_release) begin
                r_key_held <= 1'b0;
            end
        end
    end

    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_held    = r_key_held;
    assign key_release = r_key_release;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (4x4, SCAN_DIV=4, DEBOUNCE_FRAMES=3).
// A keypad model pulls column[c] low while row[r] is low and key (r,c) is held.
// Repeat expectations follow KEYPAD_REPEAT_EN.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  column;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        key_release;

    logic [15:0] keys = '0;

    int n_cmp = 0;
    int n_bad = 0;

    int frame_no  = 0;
    int n_valid   = 0;
    int n_rel     = 0;
    int rel_frame = -1;
    int vf[$];
    logic [3:0] prev_row = 4'b1111;
    logic [3:0] last_code = '0;

    keypad_scanner #(
        .ROWS            (4),
        .COLS            (4),
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3),
        .REPEAT_DELAY    (8),
        .REPEAT_RATE     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .column      (column),
        .row         (row),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    // Keypad matrix model.
    always_comb begin
        column = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && keys[r*4+c]) begin
                    column[c] = 1'b0;
                end
            end
        end
    end

    // Frame tracking and strobe logging, sampled on the falling edge.
    always @(negedge clk) begin
        if (row == 4'b1110 && prev_row == 4'b0111) begin
            frame_no = frame_no + 1;
        end
        prev_row = row;
        if (key_valid) begin
            n_valid   = n_valid + 1;
            last_code = key_code;
            vf.push_back(frame_no);
        end
        if (key_release) begin
            n_rel     = n_rel + 1;
            rel_frame = frame_no;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Wait for n frame starts; returns just after the edge ending dwell 0 of row 0.
    task automatic wait_frames(input int n);
        int f;
        bit ok;
        for (int k = 0; k < n; k++) begin
            f  = frame_no;
            ok = 1'b0;
            for (int c = 0; c < 40 && !ok; c++) begin
                @(posedge clk);
                if (frame_no != f) ok = 1'b1;
            end
            if (!ok) check("frame_timeout", 0, 1);
        end
        #1;
    endtask

    initial begin
        int base;
        int v0;
        int r0;
        int q0;
        logic [3:0] exp_row;

        // Power-on reset, then get a key accepted so the mid-scan reset has state to discard.
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        wait_frames(1);
        keys = 16'(1) << 14;
        wait_frames(4);
        check("pre_rst_held", int'(key_held), 1);
        check("pre_rst_code", int'(key_code), 14);

        // Test 1: asynchronous reset mid-scan.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_row", int'(row), 4'b1110);
        check("rst_code", int'(key_code), 0);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_release", int'(key_release), 0);
        keys = '0;
        @(negedge clk) rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            check($sformatf("rot_row_%0d", k), int'(row), int'(exp_row));
        end

        // Test 2: hold (2,1) for 6 frames -> single strobe, code 9, end of frame 3.
        wait_frames(1);
        base = frame_no;
        v0   = n_valid;
        keys = 16'(1) << 9;
        wait_frames(6);
        check("t2_valid_count", n_valid - v0, 1);
        check("t2_valid_frame", vf[vf.size()-1] - base, 3);
        check("t2_code", int'(last_code), 9);
        check("t2_held", int'(key_held), 1);

        // Test 4: release with a one-frame bounce -> release after 3 clean frames.
        base = frame_no;
        v0   = n_valid;
        r0   = n_rel;
        keys = '0;
        wait_frames(1);
        keys = 16'(1) << 9;
        wait_frames(1);
        keys = '0;
        wait_frames(2);
        check("t4_held_mid", int'(key_held), 1);
        wait_frames(2);
        check("t4_rel_count", n_rel - r0, 1);
        check("t4_rel_frame", rel_frame - base, 5);
        check("t4_held_after", int'(key_held), 0);
        check("t4_no_valid", n_valid - v0, 0);

        // Test 3: 2-frame press aborts; a fresh press needs the full 3 frames.
        base = frame_no;
        v0   = n_valid;
        keys = 16'(1) << 9;
        wait_frames(2);
        keys = '0;
        wait_frames(1);
        check("t3_no_valid", n_valid - v0, 0);
        keys = 16'(1) << 9;
        wait_frames(4);
        check("t3_valid_count", n_valid - v0, 1);
        check("t3_valid_frame", vf[vf.size()-1] - base, 6);
        keys = '0;
        wait_frames(4);
        check("t3_held_after", int'(key_held), 0);

        // Test 5: two keys together are ignored; dropping one accepts the other.
        v0   = n_valid;
        keys = (16'(1) << 3) | (16'(1) << 4);
        wait_frames(5);
        check("t5_multi_no_valid", n_valid - v0, 0);
        base = frame_no;
        keys = 16'(1) << 3;
        wait_frames(5);
        check("t5_valid_count", n_valid - v0, 1);
        check("t5_valid_frame", vf[vf.size()-1] - base, 3);
        check("t5_code", int'(last_code), 3);
        keys = '0;
        wait_frames(4);

        // Test 6: hold (3,1) for 14 frames; repeats only with KEYPAD_REPEAT_EN.
        base = frame_no;
        q0   = vf.size();
        r0   = n_rel;
        keys = 16'(1) << 13;
        wait_frames(14);
        keys = '0;
        wait_frames(4);
`ifdef KEYPAD_REPEAT_EN
        check("t6_valid_count", vf.size() - q0, 3);
        if (vf.size() - q0 == 3) begin
            check("t6_frame_a", vf[q0]   - base, 3);
            check("t6_frame_b", vf[q0+1] - base, 11);
            check("t6_frame_c", vf[q0+2] - base, 13);
        end
`else
        check("t6_valid_count", vf.size() - q0, 1);
        if (vf.size() - q0 == 1) begin
            check("t6_frame_a", vf[q0] - base, 3);
        end
`endif
        check("t6_code", int'(last_code), 13);
        check("t6_rel_count", n_rel - r0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
